// File: rtl/des_perm_unit.sv
// DES Initial/Final bit-permutation engine with a configurable number of output
// bits produced per cycle (64 = single step, 1 = fully serial).
module des_perm_unit #(
    parameter int BITS_PER_CYCLE = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    localparam int NSTEPS = 64 / BITS_PER_CYCLE;
    localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(NSTEPS - 1);

    if (!(BITS_PER_CYCLE == 1  || BITS_PER_CYCLE == 2  || BITS_PER_CYCLE == 4 ||
          BITS_PER_CYCLE == 8  || BITS_PER_CYCLE == 16 || BITS_PER_CYCLE == 32 ||
          BITS_PER_CYCLE == 64)) begin : g_bad_width
        $error("des_perm_unit: BITS_PER_CYCLE must be a power of two from 1 to 64");
    end

    // Entry i holds the source DES bit (1..64, MSB-first) for output DES bit i+1.
    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };
    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [63:0]     blk_q;
    logic            mode_q;
    logic [63:0]     asm_q;
    logic [63:0]     perm_ip;
    logic [63:0]     perm_fp;
    logic [63:0]     perm_full;
    logic [63:0]     asm_next;

    assign dbg_state = state_q;

    for (genvar i = 0; i < 64; i++) begin : g_perm
        assign perm_ip[63-i] = blk_q[64-IP_TAB[i]];
        assign perm_fp[63-i] = blk_q[64-FP_TAB[i]];
    end

    assign perm_full = mode_q ? perm_fp : perm_ip;

    // Only the chunk addressed by the step counter is copied into the assembly register.
    always_comb begin
        asm_next = asm_q;
        for (int s = 0; s < NSTEPS; s++) begin
            if (cnt_q == CW'(s)) begin
                asm_next[63 - s*BITS_PER_CYCLE -: BITS_PER_CYCLE] =
                    perm_full[63 - s*BITS_PER_CYCLE -: BITS_PER_CYCLE];
            end
        end
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid/out_data hold steady until out_ready, and in_ready is high only in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            blk_q     <= '0;
            mode_q    <= 1'b0;
            asm_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        blk_q    <= in_data;
                        mode_q   <= in_mode;
                        cnt_q    <= '0;
                        asm_q    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    asm_q <= asm_next;
                    if (cnt_q == LAST_STEP) begin
                        out_data  <= asm_next;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_des_perm_unit.sv
// Directed bench for des_perm_unit: four instances at 64, 8, 1 and 4 bits per cycle,
// driven from one linear initial block with hand-computed DES IP/FP vectors.
module tb_des_perm_unit;
    localparam logic [63:0] PLAIN  = 64'h0123456789ABCDEF;
    localparam logic [63:0] IP_OUT = 64'hCC00CCFFF0AAF0AA;

    logic        clk = 1'b0;
    logic        rst       [4];
    logic        in_valid  [4];
    logic        in_ready  [4];
    logic [63:0] in_data   [4];
    logic        in_mode   [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic [63:0] out_data  [4];
    logic        busy      [4];
    logic [1:0]  dbg_state [4];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        des_perm_unit #(
            .BITS_PER_CYCLE((g == 0) ? 64 : (g == 1) ? 8 : (g == 2) ? 1 : 4)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_mode   (in_mode[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g]),
            .dbg_state (dbg_state[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] status(input int u);
        return 64'({in_ready[u], out_valid[u], busy[u]});
    endfunction

    task automatic send(input int u, input logic [63:0] d, input logic m);
        check($sformatf("in_ready_before_accept_u%0d", u), 64'(in_ready[u]), 64'd1);
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        in_mode[u]  = m;
        tick();
        in_valid[u] = 1'b0;
    endtask

    task automatic wait_out(input int u, input int lat, input logic [63:0] exp, input string tag);
        int cyc = 0;
        int bcnt = 0;
        while (!out_valid[u] && cyc < 200) begin
            if (busy[u]) bcnt++;
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(lat));
        check({tag, "_data"}, out_data[u], exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 4; u++) begin
            rst[u]       = 1'b1;
            in_valid[u]  = 1'b0;
            in_data[u]   = '0;
            in_mode[u]   = 1'b0;
            out_ready[u] = 1'b1;
        end
        in_valid[0] = 1'b1;
        repeat (3) tick();

        for (int u = 0; u < 4; u++) begin
            check($sformatf("reset_status_u%0d", u), status(u), 64'b100);
            check($sformatf("reset_data_u%0d", u), out_data[u], 64'd0);
            check($sformatf("reset_state_u%0d", u), 64'(dbg_state[u]), 64'd0);
        end
        in_valid[0] = 1'b0;
        for (int u = 0; u < 4; u++) rst[u] = 1'b0;
        tick();

        // B=64 IP, then return to IDLE two cycles after accept
        send(0, PLAIN, 1'b0);
        wait_out(0, 1, IP_OUT, "ip_b64");
        check("ip_b64_in_ready_in_done", 64'(in_ready[0]), 64'd0);
        tick();
        check("ip_b64_back_to_idle", status(0), 64'b100);

        send(0, IP_OUT, 1'b1);
        wait_out(0, 1, PLAIN, "fp_b64");
        tick();
        send(0, 64'h0000000001000000, 1'b1);
        wait_out(0, 1, 64'h8000000000000000, "fp_b64_single_bit");
        tick();

        // Narrow datapaths produce the same result, just later
        send(1, PLAIN, 1'b0);
        wait_out(1, 8, IP_OUT, "ip_b8");
        tick();
        send(2, PLAIN, 1'b0);
        wait_out(2, 64, IP_OUT, "ip_b1");
        tick();
        send(1, 64'h8000000000000000, 1'b0);
        wait_out(1, 8, 64'h0000000001000000, "ip_b8_single_bit");
        tick();

        // Back-pressure in DONE with a new block already offered
        out_ready[1] = 1'b0;
        send(1, IP_OUT, 1'b1);
        wait_out(1, 8, PLAIN, "bp_first");
        in_valid[1] = 1'b1;
        in_data[1]  = PLAIN;
        in_mode[1]  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold_status_%0d", i), status(1), 64'b010);
            check($sformatf("bp_hold_data_%0d", i), out_data[1], PLAIN);
            tick();
        end
        out_ready[1] = 1'b1;
        tick();
        check("bp_release_idle", status(1), 64'b100);
        check("bp_release_data", out_data[1], PLAIN);
        tick();
        in_valid[1] = 1'b0;
        wait_out(1, 8, IP_OUT, "bp_second");
        tick();

        // Mode and data changes after acceptance must not leak into the block in flight
        send(1, IP_OUT, 1'b1);
        in_mode[1] = 1'b0;
        in_data[1] = 64'hFFFF000012345678;
        wait_out(1, 8, PLAIN, "mode_isolation");
        tick();

        // Reset in the middle of BUSY at step 7 on the 4-bit instance
        send(3, PLAIN, 1'b0);
        repeat (7) tick();
        check("rst_mid_busy_before", status(3), 64'b001);
        rst[3] = 1'b1;
        tick();
        rst[3] = 1'b0;
        check("rst_mid_busy_status", status(3), 64'b100);
        check("rst_mid_busy_data", out_data[3], 64'd0);
        tick();
        check("rst_mid_busy_no_valid", status(3), 64'b100);
        send(3, PLAIN, 1'b0);
        wait_out(3, 16, IP_OUT, "ip_b4_after_reset");
        tick();
        check("ip_b4_back_to_idle", status(3), 64'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
